// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the DDR request scheduler.
//   - default index / cacheline widths
//   - scheduler FSM state encoding
//   - request owner encoding (icache = 0, dcache = 1)
//   - round-robin grant helper
package ddr_sched_pkg;

  localparam int unsigned DDR_IDX_W_DEFAULT  = 64;
  localparam int unsigned DDR_LINE_W_DEFAULT = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_e;

  // Sole requester wins; on a tie the side not granted last time wins.
  // With no requester the result is irrelevant (readies are gated by valid).
  function automatic owner_e rr_grant(input logic ic_valid,
                                      input logic dc_valid,
                                      input owner_e last);
    owner_e g;
    if (ic_valid && dc_valid) begin
      if (last == OWNER_IC) g = OWNER_DC;
      else                  g = OWNER_IC;
    end else if (dc_valid) begin
      g = OWNER_DC;
    end else begin
      g = OWNER_IC;
    end
    return g;
  endfunction

endpackage

// File: rtl/ddr_sched_if.sv
// Bundle of every scheduler-facing bus signal.
//   icache : ic_req_valid/ready/index, ic_resp_valid/data
//   dcache : dc_req_valid/ready/index/write/wdata/wmask, dc_resp_valid/data
//   DDR    : ddr_chip_enable/index/write_enable/burst_mode/write_mask/write_data,
//            ddr_read_data, ddr_operation_done, ddr_ready
// Modports: slave = scheduler view, master = environment (caches + DDR) view.
interface ddr_sched_if
  import ddr_sched_pkg::*;
#(
  parameter int unsigned IDX_W  = DDR_IDX_W_DEFAULT,
  parameter int unsigned LINE_W = DDR_LINE_W_DEFAULT
) ();

  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [IDX_W-1:0]  ic_req_index;
  logic              ic_resp_valid;
  logic [LINE_W-1:0] ic_resp_data;

  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [IDX_W-1:0]  dc_req_index;
  logic              dc_req_write;
  logic [LINE_W-1:0] dc_req_wdata;
  logic [LINE_W-1:0] dc_req_wmask;
  logic              dc_resp_valid;
  logic [LINE_W-1:0] dc_resp_data;

  logic              ddr_chip_enable;
  logic [IDX_W-1:0]  ddr_index;
  logic              ddr_write_enable;
  logic              ddr_burst_mode;
  logic [LINE_W-1:0] ddr_write_mask;
  logic [LINE_W-1:0] ddr_write_data;
  logic [LINE_W-1:0] ddr_read_data;
  logic              ddr_operation_done;
  logic              ddr_ready;

  modport slave (
    input  ic_req_valid, ic_req_index,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_index, dc_req_write, dc_req_wdata, dc_req_wmask,
    output dc_req_ready, dc_resp_valid, dc_resp_data,
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_write_mask, ddr_write_data,
    input  ddr_read_data, ddr_operation_done, ddr_ready
  );

  modport master (
    output ic_req_valid, ic_req_index,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_index, dc_req_write, dc_req_wdata, dc_req_wmask,
    input  dc_req_ready, dc_resp_valid, dc_resp_data,
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_write_mask, ddr_write_data,
    output ddr_read_data, ddr_operation_done, ddr_ready
  );

endinterface

// File: rtl/ddr_sched.sv
// DDR request scheduler: arbitrates icache line reads and dcache fills /
// write-backs onto a single DDR port, one outstanding operation at a time.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high
//   bus   - ddr_sched_if.slave (cache request/response + DDR command/return)
// Flow: IDLE (grant, latch) -> ISSUE (one strobe once ddr_ready) -> WAIT
// (until ddr_operation_done) -> RESP (one-cycle response to owner) -> IDLE.
module ddr_sched
  import ddr_sched_pkg::*;
#(
  parameter int unsigned IDX_W  = DDR_IDX_W_DEFAULT,
  parameter int unsigned LINE_W = DDR_LINE_W_DEFAULT
) (
  input  logic      clock,
  input  logic      reset,
  ddr_sched_if.slave bus
);

  sched_state_e      state, state_next;
  owner_e            last_grant, owner, grant;
  logic              accept;

  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic              burst_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] wmask_q;
  logic [LINE_W-1:0] rdata_q;

  logic              ic_ready, dc_ready, strobe, ic_resp, dc_resp;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = rr_grant(bus.ic_req_valid, bus.dc_req_valid, last_grant);
    ic_ready   = 1'b0;
    dc_ready   = 1'b0;
    accept     = 1'b0;
    strobe     = 1'b0;
    ic_resp    = 1'b0;
    dc_resp    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ic_ready = bus.ic_req_valid && (grant == OWNER_IC);
        dc_ready = bus.dc_req_valid && (grant == OWNER_DC);
        accept   = ic_ready || dc_ready;
        if (accept) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        strobe = bus.ddr_ready;
        if (bus.ddr_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ddr_operation_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        ic_resp    = (owner == OWNER_IC);
        dc_resp    = (owner == OWNER_DC);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are latched at accept so the requester may drop its
  // inputs immediately; an icache read issues zero data and mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= OWNER_DC;
      owner      <= OWNER_IC;
      idx_q      <= '0;
      we_q       <= 1'b0;
      burst_q    <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        owner      <= grant;
        if (grant == OWNER_IC) begin
          idx_q   <= bus.ic_req_index;
          we_q    <= 1'b0;
          burst_q <= 1'b1;
          wdata_q <= '0;
          wmask_q <= '0;
        end else begin
          idx_q   <= bus.dc_req_index;
          we_q    <= bus.dc_req_write;
          burst_q <= 1'b0;
          wdata_q <= bus.dc_req_wdata;
          wmask_q <= bus.dc_req_wmask;
        end
      end
      if ((state == ST_WAIT) && bus.ddr_operation_done) rdata_q <= bus.ddr_read_data;
    end
  end

  assign bus.ic_req_ready     = ic_ready;
  assign bus.dc_req_ready     = dc_ready;
  assign bus.ic_resp_valid    = ic_resp;
  assign bus.dc_resp_valid    = dc_resp;
  assign bus.ic_resp_data     = rdata_q;
  assign bus.dc_resp_data     = rdata_q;
  assign bus.ddr_chip_enable  = strobe;
  assign bus.ddr_index        = idx_q;
  assign bus.ddr_write_enable = we_q;
  assign bus.ddr_burst_mode   = burst_q;
  assign bus.ddr_write_data   = wdata_q;
  assign bus.ddr_write_mask   = wmask_q;

endmodule

// File: tb/tb_ddr_sched.sv
// Directed testbench for ddr_sched: reset values, single icache read,
// round-robin tie breaking, dcache write-back, ddr_ready back-pressure,
// stray done pulses, and reset during an outstanding operation.
module tb_ddr_sched;
  import ddr_sched_pkg::*;

  localparam int unsigned IDX_W  = 64;
  localparam int unsigned LINE_W = 512;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  ddr_sched_if #(.IDX_W(IDX_W), .LINE_W(LINE_W)) bus ();

  ddr_sched #(.IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ic_req_valid       = 1'b0;
    bus.ic_req_index       = '0;
    bus.dc_req_valid       = 1'b0;
    bus.dc_req_index       = '0;
    bus.dc_req_write       = 1'b0;
    bus.dc_req_wdata       = '0;
    bus.dc_req_wmask       = '0;
    bus.ddr_read_data      = '0;
    bus.ddr_operation_done = 1'b0;
    bus.ddr_ready          = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ic_rdy"},  bus.ic_req_ready,     0);
    check({tag, ".dc_rdy"},  bus.dc_req_ready,     0);
    check({tag, ".ic_resp"}, bus.ic_resp_valid,    0);
    check({tag, ".dc_resp"}, bus.dc_resp_valid,    0);
    check({tag, ".ce"},      bus.ddr_chip_enable,  0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_quiet(tag);
    check({tag, ".idx"},   bus.ddr_index,        0);
    check({tag, ".we"},    bus.ddr_write_enable, 0);
    check({tag, ".burst"}, bus.ddr_burst_mode,   0);
    check({tag, ".wdata"}, bus.ddr_write_data,   0);
    check({tag, ".wmask"}, bus.ddr_write_mask,   0);
    check({tag, ".icd"},   bus.ic_resp_data,     0);
    check({tag, ".dcd"},   bus.dc_resp_data,     0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Called with inputs already applied in IDLE: check the grant, then clock it in.
  task automatic accept(input string tag, input logic exp_ic);
    #1;
    check({tag, ".ic_rdy"}, bus.ic_req_ready, exp_ic);
    check({tag, ".dc_rdy"}, bus.dc_req_ready, !exp_ic);
    tick();
  endtask

  // Called one cycle after accept (ISSUE) with ddr_ready high.
  task automatic serve(input string tag, input logic is_ic, input int unsigned wait_cycles,
                       input logic [LINE_W-1:0] rd, input logic chk_data);
    check({tag, ".ce"},     bus.ddr_chip_enable, 1);
    check({tag, ".rdy_is"}, bus.ic_req_ready | bus.dc_req_ready, 0);
    tick();
    check({tag, ".ce_off"}, bus.ddr_chip_enable, 0);
    for (int unsigned i = 0; i < wait_cycles; i++) begin
      check({tag, ".wait_resp"}, bus.ic_resp_valid | bus.dc_resp_valid, 0);
      tick();
    end
    bus.ddr_read_data      = rd;
    bus.ddr_operation_done = 1'b1;
    tick();
    bus.ddr_operation_done = 1'b0;
    bus.ddr_read_data      = '0;
    check({tag, ".ic_resp"}, bus.ic_resp_valid, is_ic);
    check({tag, ".dc_resp"}, bus.dc_resp_valid, !is_ic);
    check({tag, ".rdy_rs"},  bus.ic_req_ready | bus.dc_req_ready, 0);
    if (chk_data) begin
      if (is_ic) check({tag, ".icd"}, bus.ic_resp_data, rd);
      else       check({tag, ".dcd"}, bus.dc_resp_data, rd);
    end
    tick();
    check({tag, ".pulse"}, bus.ic_resp_valid | bus.dc_resp_valid, 0);
  endtask

  logic [LINE_W-1:0] pat_a, pat_b, pat_c, pat_5a, ones;

  initial begin
    pat_a  = {16{32'hDEAD_0001}};
    pat_b  = {16{32'h1234_5678}};
    pat_c  = {16{32'h0BAD_F00D}};
    pat_5a = {64{8'hA5}};
    ones   = '1;
    idle_inputs();
    do_reset();
    check_reset_outputs("rst");

    // Single icache read, done 5 cycles after the strobe.
    bus.ic_req_valid = 1'b1;
    bus.ic_req_index = 64'h1000;
    accept("ic1", 1'b1);
    bus.ic_req_valid = 1'b0;
    bus.ic_req_index = '0;
    check("ic1.idx",   bus.ddr_index,        64'h1000);
    check("ic1.burst", bus.ddr_burst_mode,   1);
    check("ic1.we",    bus.ddr_write_enable, 0);
    serve("ic1", 1'b1, 4, pat_a, 1'b1);

    // Done pulse while IDLE must not produce a response.
    bus.ddr_operation_done = 1'b1;
    tick();
    bus.ddr_operation_done = 1'b0;
    check_quiet("idle_done");

    // Ties after reset: icache first, then alternate.
    do_reset();
    bus.ic_req_valid = 1'b1;
    bus.ic_req_index = 64'h80;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_index = 64'h40;
    accept("tie0", 1'b1);
    check("tie0.idx", bus.ddr_index, 64'h80);
    serve("tie0", 1'b1, 0, pat_b, 1'b1);
    accept("tie1", 1'b0);
    check("tie1.idx",   bus.ddr_index,      64'h40);
    check("tie1.burst", bus.ddr_burst_mode, 0);
    serve("tie1", 1'b0, 1, pat_c, 1'b1);
    accept("tie2", 1'b1);
    serve("tie2", 1'b1, 0, pat_a, 1'b1);
    accept("tie3", 1'b0);
    bus.ic_req_valid = 1'b0;
    bus.dc_req_valid = 1'b0;
    serve("tie3", 1'b0, 0, pat_b, 1'b1);

    // dcache write-back; requester inputs change right after accept.
    bus.dc_req_valid = 1'b1;
    bus.dc_req_index = 64'h2040;
    bus.dc_req_write = 1'b1;
    bus.dc_req_wdata = pat_5a;
    bus.dc_req_wmask = ones;
    accept("wr", 1'b0);
    bus.dc_req_valid = 1'b0;
    bus.dc_req_write = 1'b0;
    bus.dc_req_wdata = '0;
    bus.dc_req_wmask = '0;
    bus.dc_req_index = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      check("wr.idx",   bus.ddr_index,        64'h2040);
      check("wr.we",    bus.ddr_write_enable, 1);
      check("wr.burst", bus.ddr_burst_mode,   0);
      check("wr.data",  bus.ddr_write_data,   pat_5a);
      check("wr.mask",  bus.ddr_write_mask,   ones);
      if (c < 2) tick();
    end
    // ddr_ready is high, so the ISSUE cycle was the first one above; the
    // remaining two cycles were WAIT. Finish with the response.
    bus.ddr_operation_done = 1'b1;
    tick();
    bus.ddr_operation_done = 1'b0;
    check("wr.dc_resp", bus.dc_resp_valid, 1);
    check("wr.ic_resp", bus.ic_resp_valid, 0);
    tick();
    check_quiet("wr.after");

    // ddr_ready low for 3 cycles in ISSUE; a done pulse there is ignored.
    bus.ddr_ready    = 1'b0;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_index = 64'h3000;
    accept("bp", 1'b1);
    bus.ic_req_valid = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      check("bp.no_ce", bus.ddr_chip_enable, 0);
      bus.ddr_operation_done = (c == 1);
      tick();
      bus.ddr_operation_done = 1'b0;
      check("bp.no_resp", bus.ic_resp_valid, 0);
    end
    bus.ddr_ready = 1'b1;
    #1;
    check("bp.idx", bus.ddr_index, 64'h3000);
    serve("bp", 1'b1, 2, pat_c, 1'b1);

    // Reset while WAITing, then a late done pulse.
    bus.dc_req_valid = 1'b1;
    bus.dc_req_index = 64'h5000;
    bus.dc_req_write = 1'b0;
    accept("rw", 1'b0);
    bus.dc_req_valid = 1'b0;
    check("rw.ce", bus.ddr_chip_enable, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ddr_read_data      = pat_a;
    bus.ddr_operation_done = 1'b1;
    tick();
    bus.ddr_operation_done = 1'b0;
    bus.ddr_read_data      = '0;
    check_reset_outputs("rw.after");
    tick();
    check_reset_outputs("rw.after2");
    // last_grant was reset to dcache, so a tie goes to icache.
    bus.ic_req_valid = 1'b1;
    bus.dc_req_valid = 1'b1;
    accept("rw.tie", 1'b1);
    bus.ic_req_valid = 1'b0;
    bus.dc_req_valid = 1'b0;
    serve("rw.tie", 1'b1, 0, pat_b, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ddr_sched.md
DDR_SCHED -- requirements
Module: ddr_sched

Interface
REQ-001 Parameter IDX_W, default 64, DDR index width.
REQ-002 Parameter LINE_W, default 512, cacheline data/mask width.
REQ-003 clock  input  1  single clock, all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ic_req_valid  input  1  icache line-read request.
REQ-006 ic_req_ready  output  1  icache request accepted this cycle when high with valid.
REQ-007 ic_req_index  input  IDX_W  icache line address.
REQ-008 ic_resp_valid  output  1  one-cycle pulse, icache read data valid.
REQ-009 ic_resp_data  output  LINE_W  icache read line.
REQ-010 dc_req_valid  input  1  dcache request.
REQ-011 dc_req_ready  output  1  dcache request accepted when high with valid.
REQ-012 dc_req_index  input  IDX_W  dcache line address.
REQ-013 dc_req_write  input  1  1 = write-back, 0 = line fill.
REQ-014 dc_req_wdata  input  LINE_W  write line.
REQ-015 dc_req_wmask  input  LINE_W  per-bit write mask.
REQ-016 dc_resp_valid  output  1  one-cycle pulse, dcache operation complete (read data valid if read).
REQ-017 dc_resp_data  output  LINE_W  dcache read line.
REQ-018 ddr_chip_enable  output  1  one-cycle issue strobe.
REQ-019 ddr_index  output  IDX_W  issued address.
REQ-020 ddr_write_enable  output  1  1 = write.
REQ-021 ddr_burst_mode  output  1  1 for icache transfers, 0 for dcache.
REQ-022 ddr_write_mask  output  LINE_W  issued mask.
REQ-023 ddr_write_data  output  LINE_W  issued data.
REQ-024 ddr_read_data  input  LINE_W  read return.
REQ-025 ddr_operation_done  input  1  one-cycle completion pulse.
REQ-026 ddr_ready  input  1  DDR accepts a new strobe.

Function
REQ-027 FSM states IDLE, ISSUE, WAIT, RESP; one outstanding DDR operation max.
REQ-028 IDLE: ready SHALL be high only toward the granted requester; grant = sole valid requester, or if both valid, the one not granted last (round-robin).
REQ-029 Handshake ready&valid latches index/write/wdata/wmask and owner into registers, updates last_grant, IDLE->ISSUE; requester may drop inputs next cycle.
REQ-030 ISSUE: ddr_chip_enable high for exactly one cycle, the first cycle ddr_ready is high; then ->WAIT; no strobe while ddr_ready low.
REQ-031 ddr_index/write_enable/write_data/write_mask/burst_mode SHALL hold the latched request from ISSUE through WAIT.
REQ-032 WAIT: on ddr_operation_done capture ddr_read_data, ->RESP; done outside WAIT ignored.
REQ-033 RESP: owner's resp_valid high one cycle with captured data (latency done->resp_valid = 1 cycle), ->IDLE; both ready low in ISSUE/WAIT/RESP.
REQ-034 Minimum accept-to-accept spacing 4 cycles; done arriving the same cycle as ddr_ready change has no effect on WAIT.
REQ-035 Writes also return dc_resp_valid; dc_resp_data then undefined-but-stable (last captured value).

Reset
REQ-036 Reset SHALL force IDLE, last_grant=dcache (icache wins first tie), all valid/ready/strobe outputs 0, data/index/mask outputs 0.
REQ-037 Reset mid-operation SHALL abandon the transaction with no resp_valid; later ddr_operation_done ignored.

Structure
REQ-038 State enum and owner encoding (IC=0, DC=1) in the shared defines package; IDX_W/LINE_W default from existing range macros.
REQ-039 Single flat module; no sub-module.

Verification
REQ-040 ic read 0x1000 alone, ddr_ready=1, done 5 cycles after strobe -> burst_mode=1, write_enable=0, ic_resp_valid 1 cycle after done with read data.
REQ-041 ic and dc valid same cycle after reset -> ic granted first, dc granted next IDLE; repeated ties alternate.
REQ-042 dc write 0x2040, mask all-ones, data 0xA5 pattern -> write_enable=1, burst_mode=0, data/mask on bus until done, dc_resp_valid pulse.
REQ-043 ddr_ready low 3 cycles in ISSUE -> no strobe until ready high, then single-cycle strobe.
REQ-044 reset asserted in WAIT then done pulse -> no resp_valid, FSM IDLE, outputs at reset values.
